// File: rtl/fifo_stream_reader_pkg.sv
// Shared video/stream constants and the read-credit helper for the FIFO stream reader.
package fifo_stream_reader_pkg;

  localparam int DW_DEF       = 24;
  localparam int H_ACTIVE_DEF = 1024;
  localparam int V_ACTIVE_DEF = 768;
  localparam int CW_DEF       = 12;

  typedef logic [1:0] occ_t;

  // A new read is allowed only if every word already owed (buffered + returning) still fits.
  function automatic logic has_credit(input occ_t occ, input logic inflight, input logic pop);
    return ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
  endfunction

endpackage

// File: rtl/fifo_stream_reader_skid2.sv
// Two-entry in-order skid buffer; head is registered and drives the output stream directly.
// A push into a full buffer without a simultaneous pop is dropped; the parent flags that case.
module fifo_stream_reader_skid2
  import fifo_stream_reader_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] push_dat_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output occ_t          occ_o,
  output logic [DW-1:0] head_o
);

  occ_t          occ_q, occ_d;
  logic [DW-1:0] e0_q, e0_d, e1_q, e1_d;
  logic          pop_ok;

  assign pop_ok = pop_i & (occ_q != 2'd0);

  always_comb begin
    occ_d = occ_q;
    e0_d  = e0_q;
    e1_d  = e1_q;
    if (flush_i) begin
      occ_d = 2'd0;
    end else begin
      case ({push_i, pop_ok})
        2'b11: begin
          if (occ_q == 2'd2) begin
            e0_d = e1_q;
            e1_d = push_dat_i;
          end else begin
            e0_d = push_dat_i;
          end
        end
        2'b10: begin
          if (occ_q == 2'd0) begin
            e0_d  = push_dat_i;
            occ_d = 2'd1;
          end else if (occ_q == 2'd1) begin
            e1_d  = push_dat_i;
            occ_d = 2'd2;
          end
        end
        2'b01: begin
          e0_d  = e1_q;
          occ_d = occ_q - 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= 2'd0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      occ_q <= occ_d;
      e0_q  <= e0_d;
      e1_q  <= e1_d;
    end
  end

  assign occ_o  = occ_q;
  assign head_o = e0_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops the async FIFO under credit control and streams pixels with sof/eol markers.
// FIFO read to m_valid is 2 clk; 1 pixel/clk under continuous m_ready, lossless on backpressure.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int CW       = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          flush,
  input  logic          fifo_empty,
  output logic          fifo_re,
  input  logic [DW-1:0] fifo_dout,
  input  logic          fifo_dout_valid,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_sof,
  output logic          m_eol,
  output logic          err_ovf
);

  occ_t          occ;
  logic          pop, push, ovf;
  logic          inflight_q;
  logic          err_ovf_q;
  logic [CW-1:0] x_q, x_d, y_q, y_d;

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid & m_ready;
  assign fifo_re = en & ~fifo_empty & ~flush & has_credit(occ, inflight_q, pop);

  // Flush wins over everything, so a word landing during flush is simply not pushed.
  assign push = fifo_dout_valid & ~flush & ((occ != 2'd2) | pop);
  assign ovf  = fifo_dout_valid & ~flush & (occ == 2'd2) & ~pop;

  fifo_stream_reader_skid2 #(.DW(DW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push),
    .push_dat_i(fifo_dout),
    .pop_i     (pop),
    .flush_i   (flush),
    .occ_o     (occ),
    .head_o    (m_data)
  );

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (flush) begin
      x_d = '0;
      y_d = '0;
    end else if (pop) begin
      if (x_q == CW'(H_ACTIVE - 1)) begin
        x_d = '0;
        y_d = (y_q == CW'(V_ACTIVE - 1)) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      err_ovf_q  <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      inflight_q <= fifo_re & ~fifo_empty;
      err_ovf_q  <= err_ovf_q | ovf;
      x_q        <= x_d;
      y_q        <= y_d;
    end
  end

  assign m_sof   = m_valid & (x_q == '0) & (y_q == '0);
  assign m_eol   = m_valid & (x_q == CW'(H_ACTIVE - 1));
  assign err_ovf = err_ovf_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !ovf);

endmodule
